// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcodes, alu_ops bit
// positions and instruction field positions.
package alu_issue_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 16;
  localparam int NREG    = 8;
  localparam int REG_AW  = 3;
  localparam int NOPS    = 7;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_LDI  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;

  // One-hot alu_ops bit indices: {mov,add,sub,mul,ldi,addi,subi}
  localparam int OPS_MOV  = 6;
  localparam int OPS_ADD  = 5;
  localparam int OPS_SUB  = 4;
  localparam int OPS_MUL  = 3;
  localparam int OPS_LDI  = 2;
  localparam int OPS_ADDI = 1;
  localparam int OPS_SUBI = 0;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Zero-extend an 8-bit immediate to the datapath width.
  function automatic logic [DATA_W-1:0] zext_imm(input logic [7:0] imm);
    return {{(DATA_W-8){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_reg_file8x16.sv
// 8x16 register file: two asynchronous read ports, a debug read port and one
// synchronous write port; asynchronous reset clears every entry.
module reg_file8x16
  import alu_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode / operand fetch / writeback stage around the 16-bit ALU. One
// instruction per cycle, result written back one cycle later with forwarding.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               hold,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [NOPS-1:0]    alu_ops,
  input  logic [DATA_W-1:0]  alu_in,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               illegal,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready; instr_ready is simply !hold, and fetch keeps
  // instr stable while it is not accepted.
  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs;
  logic [7:0]        imm;
  logic              accept, op_legal, op_illegal;
  logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b;
  logic [DATA_W-1:0] next_a, next_b;
  logic [NOPS-1:0]   next_ops;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;

  assign op  = instr[OP_HI:OP_LO];
  assign rd  = instr[RD_HI:RD_LO];
  assign rs  = instr[RS_HI:RS_LO];
  assign imm = instr[IMM_HI:IMM_LO];

  assign instr_ready = !hold;
  assign accept      = instr_valid && !hold;
  assign op_illegal  = op[3];
  assign op_legal    = (op != OP_NOP) && !op[3];

  assign wb_valid = ex_valid && !hold;
  assign wb_rd    = ex_rd;
  assign wb_data  = alu_in;

  reg_file8x16 u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (rd),
    .ra_data  (rf_a),
    .rb_addr  (rs),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_valid),
    .waddr    (ex_rd),
    .wdata    (alu_in)
  );

  // alu_in is only meaningful (not Z) while a writeback is live.
  assign fwd_a = (wb_valid && (ex_rd == rd)) ? alu_in : rf_a;
  assign fwd_b = (wb_valid && (ex_rd == rs)) ? alu_in : rf_b;

  always_comb begin
    next_a   = '0;
    next_b   = '0;
    next_ops = '0;
    case (op)
      OP_MOV:  begin next_b = fwd_b;                                   next_ops[OPS_MOV]  = 1'b1; end
      OP_ADD:  begin next_a = fwd_a; next_b = fwd_b;                   next_ops[OPS_ADD]  = 1'b1; end
      OP_SUB:  begin next_a = fwd_a; next_b = fwd_b;                   next_ops[OPS_SUB]  = 1'b1; end
      OP_MUL:  begin next_a = fwd_a; next_b = fwd_b;                   next_ops[OPS_MUL]  = 1'b1; end
      OP_LDI:  begin next_a = zext_imm(imm);                           next_ops[OPS_LDI]  = 1'b1; end
      OP_ADDI: begin next_a = fwd_a; next_b = zext_imm(imm);           next_ops[OPS_ADDI] = 1'b1; end
      OP_SUBI: begin next_a = fwd_a; next_b = zext_imm(imm);           next_ops[OPS_SUBI] = 1'b1; end
      default: begin next_ops = '0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ops  <= '0;
    end else if (!hold) begin
      if (accept && op_legal) begin
        ex_valid <= 1'b1;
        ex_rd    <= rd;
        alu_a    <= next_a;
        alu_b    <= next_b;
        alu_ops  <= next_ops;
      end else begin
        ex_valid <= 1'b0;
        alu_ops  <= '0;
      end
    end
  end

  // accept already excludes hold, so the pulse can never stretch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= accept && op_illegal;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch/writeback stage wrapped around the 16-bit datapath ALU of the MLP core.
- Accepts one instruction word per cycle from the fetch unit and decodes it into the 7-bit one-hot ALU op vector.
- Reads an 8x16 register file, registers the ALU operands, and writes the ALU result back to the destination register one cycle later, with forwarding.

Parameters:
DATA_W, 16, datapath width
INSTR_W, 16, instruction word width
NREG, 8, register count (address width 3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  fetch presents instruction
instr  in  INSTR_W  instruction word
instr_ready  out  1  stage accepts instruction; equals !hold
hold  in  1  controller freeze
alu_a  out  DATA_W  registered ALU operand a
alu_b  out  DATA_W  registered ALU operand b
alu_ops  out  7  registered one-hot {mov,add,sub,mul,ldi,addi,subi}
alu_in  in  DATA_W  ALU result (combinational return)
wb_valid  out  1  writeback occurring this cycle
wb_rd  out  3  writeback register
wb_data  out  DATA_W  writeback value (= alu_in)
illegal  out  1  one-cycle pulse on an undefined opcode
dbg_addr  in  3  debug read address
dbg_data  out  DATA_W  combinational register file read

Behaviour:
- Instruction format: op = [15:12], rd = [11:9].
  - R-type: rs = [8:6], bits [5:0] are ignored.
  - I-type: imm8 = [7:0], bit 8 is ignored.
- Opcodes:
  - 0 nop
  - 1 mov: a=0, b=R[rs]
  - 2 add: a=R[rd], b=R[rs]
  - 3 sub: a=R[rd], b=R[rs]
  - 4 mul: a=R[rd], b=R[rs]
  - 5 ldi: a={8'h00,imm8}, b=0; ALU gives imm8<<8
  - 6 addi: a=R[rd], b={8'h00,imm8}
  - 7 subi: a=R[rd], b={8'h00,imm8}
  - 8-15 illegal
- Destination is always rd. The result is ALU output truncated to DATA_W (mul keeps the low 16 bits).
- Pipeline registers: ex_valid, ex_rd, alu_a, alu_b, alu_ops.
- Accept: instr_valid && !hold at a rising edge.
  - Legal op 1-7: ex_valid<=1, operands and ops latched.
  - nop or illegal: ex_valid<=0, alu_ops<=0.
- No accept and !hold: ex_valid<=0, alu_ops<=0 (bubble).
- hold=1: all pipeline registers and the register file keep their values. wb_valid is forced to 0 while hold=1, so the pending result is written on the first edge after hold deasserts.
- Writeback: wb_valid = ex_valid && !hold, wb_rd = ex_rd, wb_data = alu_in. R[ex_rd] <= alu_in on the edge where wb_valid=1.
- Latency: instruction accepted at edge N, result on wb_* during cycle N..N+1, register updated at edge N+1. Fully pipelined, throughput one instruction per cycle.
- Forwarding: if a read address equals ex_rd and wb_valid=1, the operand mux selects alu_in instead of R[]. No stalls are ever generated.
- illegal: registered pulse, 1 for exactly one cycle after accepting opcode 8-15. Registers are unchanged.
- alu_ops=0 makes the ALU output Z. The stage never samples alu_in when ex_valid=0.
- dbg_data = R[dbg_addr], without forwarding; it shows the committed state.
- Reset (async, any time): R[0..7]=0, ex_valid=0, ex_rd=0, alu_a=0, alu_b=0, alu_ops=0, illegal=0. A pending writeback is discarded. instr_ready follows hold combinationally.
- hold and instr_valid in the same cycle: the instruction is not accepted, and fetch must hold instr stable.

Decomposition:
- Shared def package: DATA_W, opcode constants OP_NOP..OP_SUBI, alu_ops bit indices (MOV=6 .. SUBI=0), instruction field positions.
- Sub-module reg_file8x16:
  - 2 async read ports plus debug read port
  - 1 sync write port
  - async reset clears all entries
- Forwarding mux and decoder stay in alu_issue_stage.
- The bench instantiates the ALU between alu_a/alu_b/alu_ops and alu_in.

Test Plan:
- Reset, then ldi r1,0x12 -> wb_valid=1, wb_rd=1, wb_data=0x1200 the next cycle; dbg r1=0x1200; all other registers 0.
- Back-to-back ldi r1,0x01; addi r1,0x05 (forwarded) -> r1=0x0105; then subi r1,0x06 -> r1=0x00FF.
- r2=0x0003, r3=0x0004, mul r2,r3 -> r2=0x000C. r4=r5=0x0100, mul r4,r5 -> r4=0x0000 (truncation).
- Pending add with hold=1 for 3 cycles and instr_valid=1:
  - instr_ready=0, wb_valid=0, registers unchanged.
  - After release, result committed once and the held instruction accepted.
- Opcode 0xF -> illegal=1 for one cycle, wb_valid=0, dbg reads unchanged. Opcode 0 -> no illegal, no write.
- Assert rst during the cycle wb_valid=1 for mov r6,r1 -> r6 stays 0, all outputs at reset values, no write after rst deasserts.
